// File: rtl/mic_pdm_rx.sv
// mic_pdm_rx: stereo PDM microphone receiver producing per-frame ones-counts
// with a valid/ready handshake, sticky overrun flag and activity toggle.
module mic_pdm_rx #(
  parameter int CLK_DIV = 4,
  parameter int DECIM   = 64,
  parameter int W       = $clog2(DECIM + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [1:0]   mode,
  output logic         mclk,
  input  logic         dataint,
  output logic [W-1:0] sample_l,
  output logic [W-1:0] sample_r,
  output logic         sample_valid,
  input  logic         sample_ready,
  output logic         overrun,
  input  logic         ovr_clr,
  output logic         ledres
);
  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = $clog2(CLK_DIV);
  localparam int PW   = $clog2(DECIM);

  logic [DW-1:0] dc_q, dc_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [W-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d, sl_q, sl_d, sr_q, sr_d, fin_r;
  logic          run_q, mclk_q, mclk_d, valid_q, valid_d, ovr_q, ovr_d, led_q, led_d;
  logic          dc_wrap, smp_l, smp_r, frame_end, load;

  always_comb begin
    dc_wrap   = dc_q == DW'(CLK_DIV - 1);
    smp_l     = enable && dc_q == DW'(HALF - 1);
    smp_r     = enable && dc_wrap;
    frame_end = smp_r && pc_q == PW'(DECIM - 1);
    // the first enabled cycle only arms run_q so the frame starts cleanly at dc=0
    dc_d      = (!enable || !run_q || dc_wrap) ? '0 : dc_q + 1'b1;
    pc_d      = !enable ? '0 : smp_r ? (frame_end ? '0 : pc_q + 1'b1) : pc_q;
    mclk_d    = enable && dc_d < DW'(HALF);
    fin_r     = acc_r_q + W'(dataint);
    acc_l_d   = (!enable || frame_end) ? '0 : acc_l_q + W'(smp_l && dataint);
    acc_r_d   = (!enable || frame_end) ? '0 : acc_r_q + W'(smp_r && dataint);
    load      = frame_end && (!valid_q || sample_ready);
    sl_d      = load ? (mode == 2'b10 ? '0 : acc_l_q) : sl_q;
    sr_d      = load ? (mode == 2'b01 ? '0 : fin_r) : sr_q;
    valid_d   = load || (valid_q && !sample_ready);
    ovr_d     = (frame_end && valid_q && !sample_ready) || (ovr_q && !ovr_clr);
    led_d     = led_q ^ frame_end;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dc_q    <= '0;
      pc_q    <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
      run_q   <= 1'b0;
      mclk_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      dc_q    <= dc_d;
      pc_q    <= pc_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      run_q   <= enable;
      mclk_q  <= mclk_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      led_q   <= led_d;
    end
  end

  assign mclk         = mclk_q;
  assign sample_l     = sl_q;
  assign sample_r     = sr_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign ledres       = led_q;
endmodule
